// File: rtl/prog_timer.sv
`default_nettype none
// ============================================================================
// Module   : prog_timer
// Brief    : Programmable up/down timer with prescaler, one-shot or periodic
//            reload, terminal-count pulse and synchronous clear.
// Revision : 1.0 - initial release
// ============================================================================
module prog_timer #(
    parameter int WIDTH = 8,
    parameter int PRE_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             clear,
    input  logic [PRE_W-1:0] prescale,
    input  logic [WIDTH-1:0] period,
    input  logic             down,
    input  logic             oneshot,
    output logic [WIDTH-1:0] timer_time,
    output logic             tc,
    output logic             running,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] c_zero = '0;
    localparam logic [WIDTH-1:0] c_one  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [PRE_W-1:0] c_pre_one = {{(PRE_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    logic [WIDTH-1:0] r_time;
    logic [PRE_W-1:0] r_pre;
    logic             r_tc;
    logic             r_running;
    logic             r_done;

    // Configuration captured on IDLE->RUN; live inputs are ignored after that
    logic [WIDTH-1:0] r_period;
    logic [PRE_W-1:0] r_prescale;
    logic             r_down;
    logic             r_oneshot;

    logic [WIDTH-1:0] w_live_sv;
    logic [WIDTH-1:0] w_sv;
    logic [WIDTH-1:0] w_tv;
    logic [WIDTH-1:0] w_next;
    logic             w_tick;

    assign w_live_sv = down ? period : c_zero;
    assign w_sv      = r_down ? r_period : c_zero;
    assign w_tv      = r_down ? c_zero : r_period;
    assign w_tick    = (r_pre == r_prescale);

    // Reload on terminal rather than wrapping, so period=0 pulses every tick
    always_comb begin
        w_next = r_down ? (r_time - c_one) : (r_time + c_one);
        if (r_time == w_tv) begin
            w_next = w_sv;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_time     <= c_zero;
            r_pre      <= '0;
            r_tc       <= 1'b0;
            r_running  <= 1'b0;
            r_done     <= 1'b0;
            r_period   <= c_zero;
            r_prescale <= '0;
            r_down     <= 1'b0;
            r_oneshot  <= 1'b0;
        end else begin
            r_tc <= 1'b0;
            if (clear) begin
                r_state   <= S_IDLE;
                r_time    <= w_live_sv;
                r_pre     <= '0;
                r_running <= 1'b0;
                r_done    <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_time <= w_live_sv;
                        r_pre  <= '0;
                        if (start) begin
                            r_state    <= S_RUN;
                            r_running  <= 1'b1;
                            r_period   <= period;
                            r_prescale <= prescale;
                            r_down     <= down;
                            r_oneshot  <= oneshot;
                        end
                    end
                    S_RUN: begin
                        if (!start) begin
                            r_state   <= S_PAUSE;
                            r_running <= 1'b0;
                        end else if (w_tick) begin
                            r_pre  <= '0;
                            r_time <= w_next;
                            r_tc   <= (w_next == w_tv);
                            if (r_oneshot && (w_next == w_tv)) begin
                                r_state   <= S_DONE;
                                r_running <= 1'b0;
                                r_done    <= 1'b1;
                            end
                        end else begin
                            r_pre <= r_pre + c_pre_one;
                        end
                    end
                    S_PAUSE: begin
                        if (start) begin
                            r_state   <= S_RUN;
                            r_running <= 1'b1;
                        end
                    end
                    S_DONE: begin
                        r_done <= 1'b1;
                    end
                    default: begin
                        r_state   <= S_IDLE;
                        r_running <= 1'b0;
                        r_done    <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign timer_time = r_time;
    assign tc         = r_tc;
    assign running    = r_running;
    assign done       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_prog_timer.sv
`default_nettype none
// ============================================================================
// Module   : tb_prog_timer
// Brief    : Scoreboard bench for prog_timer driven by directed vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_prog_timer;

    logic       clk;
    logic       reset;
    logic       start;
    logic       clear;
    logic [7:0] prescale;
    logic [7:0] period;
    logic       down;
    logic       oneshot;
    logic [7:0] timer_time;
    logic       tc;
    logic       running;
    logic       done;

    typedef struct {
        logic [7:0] t;
        logic       tc;
        logic       run;
        logic       dn;
        string      nm;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    prog_timer #(.WIDTH(8), .PRE_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .clear      (clear),
        .prescale   (prescale),
        .period     (period),
        .down       (down),
        .oneshot    (oneshot),
        .timer_time (timer_time),
        .tc         (tc),
        .running    (running),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [7:0] t, input logic c,
                         input logic r, input logic d);
        checks++;
        if (timer_time !== t || tc !== c || running !== r || done !== d) begin
            errors++;
            $display("FAIL %s: got time=%0d tc=%b running=%b done=%b, want time=%0d tc=%b running=%b done=%b",
                     nm, timer_time, tc, running, done, t, c, r, d);
        end
    endtask

    // Monitor: outputs are registered, so every edge presents a new response
    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            check(e.nm, e.t, e.tc, e.run, e.dn);
        end
    end

    // Called at a negedge: drive, record expectation for the coming edge
    task automatic cyc(input logic s, input logic c, input logic [7:0] et,
                       input logic etc, input logic er, input logic ed,
                       input string nm);
        exp_t e;
        start = s;
        clear = c;
        e.t = et; e.tc = etc; e.run = er; e.dn = ed; e.nm = nm;
        q.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; clear = 1'b0;
        prescale = 8'd0; period = 8'd3; down = 1'b0; oneshot = 1'b0;
        @(posedge clk); #1;
        check("reset_state", 8'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        // Periodic up count, period=3
        cyc(1, 0, 8'd0, 0, 1, 0, "up_start");
        for (int i = 1; i <= 10; i++)
            cyc(1, 0, 8'(i % 4), (i % 4) == 3, 1, 0, "up_periodic");
        cyc(0, 1, 8'd0, 0, 0, 0, "up_clear");

        // One-shot down count, prescale=2, period=5
        prescale = 8'd2; period = 8'd5; down = 1'b1; oneshot = 1'b1;
        cyc(0, 0, 8'd5, 0, 0, 0, "down_idle_load");
        cyc(1, 0, 8'd5, 0, 1, 0, "down_start");
        for (int j = 1; j <= 15; j++)
            cyc(1, 0, 8'(5 - j / 3), j == 15, j != 15, j == 15, "down_count");
        for (int j = 0; j < 3; j++)
            cyc(1, 0, 8'd0, 0, 0, 1, "down_done_hold");
        cyc(0, 1, 8'd5, 0, 0, 0, "down_clear");

        // Pause at count 4 for 7 clocks
        prescale = 8'd0; period = 8'd10; down = 1'b0; oneshot = 1'b0;
        cyc(0, 1, 8'd0, 0, 0, 0, "pause_clear");
        cyc(1, 0, 8'd0, 0, 1, 0, "pause_start");
        for (int i = 1; i <= 4; i++)
            cyc(1, 0, 8'(i), 0, 1, 0, "pause_pre");
        for (int i = 0; i < 7; i++)
            cyc(0, 0, 8'd4, 0, 0, 0, "pause_hold");
        cyc(1, 0, 8'd4, 0, 1, 0, "pause_resume");
        for (int i = 5; i <= 12; i++)
            cyc(1, 0, 8'(i % 11), i == 10, 1, 0, "pause_post");
        cyc(0, 1, 8'd0, 0, 0, 0, "pause_end_clear");

        // Shadowing of period
        period = 8'd3;
        cyc(1, 0, 8'd0, 0, 1, 0, "shadow_start");
        cyc(1, 0, 8'd1, 0, 1, 0, "shadow_1");
        cyc(1, 0, 8'd2, 0, 1, 0, "shadow_2");
        period = 8'd9;
        for (int i = 3; i <= 8; i++)
            cyc(1, 0, 8'(i % 4), (i % 4) == 3, 1, 0, "shadow_old_wrap");
        cyc(0, 1, 8'd0, 0, 0, 0, "shadow_clear");
        cyc(1, 0, 8'd0, 0, 1, 0, "shadow_restart");
        for (int i = 1; i <= 11; i++)
            cyc(1, 0, 8'(i % 10), i == 9, 1, 0, "shadow_new_wrap");
        cyc(0, 1, 8'd0, 0, 0, 0, "shadow_end_clear");

        // period=0 periodic and one-shot
        period = 8'd0;
        cyc(1, 0, 8'd0, 0, 1, 0, "p0_start");
        for (int i = 0; i < 4; i++)
            cyc(1, 0, 8'd0, 1, 1, 0, "p0_tc_every_tick");
        cyc(0, 1, 8'd0, 0, 0, 0, "p0_clear");
        oneshot = 1'b1;
        cyc(1, 0, 8'd0, 0, 1, 0, "p0_os_start");
        cyc(1, 0, 8'd0, 1, 0, 1, "p0_os_done");
        cyc(1, 0, 8'd0, 0, 0, 1, "p0_os_hold");
        cyc(0, 1, 8'd0, 0, 0, 0, "p0_os_clear");

        // Asynchronous reset mid-count
        period = 8'd3; oneshot = 1'b0;
        cyc(1, 0, 8'd0, 0, 1, 0, "ar_start");
        cyc(1, 0, 8'd1, 0, 1, 0, "ar_1");
        cyc(1, 0, 8'd2, 0, 1, 0, "ar_2");
        start = 1'b0;
        #2 reset = 1'b1;
        #1 check("async_reset", 8'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        cyc(0, 0, 8'd0, 0, 0, 0, "ar_idle");
        cyc(1, 1, 8'd0, 0, 0, 0, "clear_over_start");
        cyc(0, 0, 8'd0, 0, 0, 0, "clear_no_count");

        for (int k = 0; k < 20 && q.size() > 0; k++)
            @(posedge clk);
        if (q.size() > 0) begin
            errors++;
            checks++;
            $display("FAIL drain: got %0d pending, want 0", q.size());
        end
        #2;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/prog_timer.md
# prog_timer

Parametrised, fully synchronous programmable timer: the next-generation replacement for the 8-bit ripple timer in the clock/timing library. It adds configurable width, a prescaler, up/down counting, one-shot or periodic operation, a terminal-count pulse and a synchronous clear. All outputs are registered, and the block sits between the system clock and any logic that needs a periodic tick or a timeout.

## Interface
Parameters:
- WIDTH, 8, counter width in bits (≥2)
- PRE_W, 8, prescaler width in bits (≥1)

Ports:
- clk  input  1  system clock; the only clock, all state on its rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  level-sensitive run enable: counts while high, holds while low
- clear  input  1  synchronous clear back to IDLE
- prescale  input  PRE_W  one counter step every prescale+1 clocks
- period  input  WIDTH  terminal value (up mode) or start value (down mode)
- down  input  1  0 = count up from 0 to period; 1 = count down from period to 0
- oneshot  input  1  1 = stop at terminal; 0 = reload and continue
- timer_time  output  WIDTH  current count
- tc  output  1  one-clock pulse; counter has just reached terminal
- running  output  1  high while state is RUN
- done  output  1  high while state is DONE (one-shot expired)

## Operation
- States: IDLE, RUN, PAUSE, DONE.
- SV (start value) = 0 when down=0, else period. TV (terminal value) = period when down=0, else 0.
- IDLE:
  - timer_time <= SV, computed from live inputs, every clock.
  - Prescaler is held at 0.
  - start=1 moves to RUN. On that same edge, period, down, oneshot and prescale are latched into shadow registers.
  - From then until the next return to IDLE, only the shadow copies are used. Input changes are ignored.
- RUN with start=1 (counting cycle):
  - Prescaler increments. When it equals shadow prescale, a tick occurs and the prescaler returns to 0.
  - On a tick: next = SV if timer_time==TV, else timer_time±1. Then timer_time <= next and tc <= (next==TV).
  - If oneshot=1 and next==TV, the state becomes DONE.
- RUN with start=0: move to PAUSE. No count and no tick that cycle.
- PAUSE:
  - timer_time and prescaler hold.
  - start=1 returns to RUN. Counting resumes the cycle after.
- DONE:
  - timer_time holds at TV and done=1.
  - start has no effect. Only clear or reset exits.
- clear=1 in any state:
  - Next edge gives IDLE, prescaler 0, timer_time <= live SV, tc=0.
  - clear has priority over start, ticks and the terminal-count logic.
- tc is high for exactly one clock per terminal reach and is low in all other cycles.
- Arithmetic is modulo 2^WIDTH. Because of the compare-and-reload rule, wrap never occurs in normal use.

## Timing
- Reset (asynchronous) gives: state IDLE, timer_time=0, prescaler=0, tc=0, running=0, done=0.
  - If down=1, timer_time loads period on the first clock after reset release.
- start sampled high at edge k gives RUN at k.
  - With prescale=0, the first step happens at edge k+1.
  - In general, the first step happens at edge k+prescale+1.
- tc, done and running are registered. tc and the terminal value of timer_time appear on the same edge.
- Periodic cycle length is (period+1)×(prescale+1) clocks.
- period=0:
  - Every tick produces next=TV, so tc pulses on every tick.
  - With oneshot=1, DONE is entered on the first tick.
- Mid-run input changes to period, down, oneshot or prescale have no effect until the next IDLE→RUN transition.
- Reset asserted mid-operation takes effect immediately (asynchronous). Counting restarts only after a fresh start high sampled in IDLE.
- start dropping on the same edge as a would-be tick: no step and no tc. The prescaler holds its value.

## Test plan
- WIDTH=8, prescale=0, down=0, oneshot=0, period=3, start held high → timer_time 0,1,2,3,0,1,…; tc high on each edge where the value becomes 3 (every 4 clocks); running=1.
- prescale=2, down=1, oneshot=1, period=5 → timer_time 5,4,…,0 with 3 clocks per step; a single tc and done=1 when the value reaches 0; the value holds at 0; clear → IDLE with timer_time=5.
- Pause: up mode, period=10, start dropped at count 4 for 7 clocks → timer_time stays 4 and tc stays 0; after start returns high, counting continues 5,6,… with no lost or extra steps.
- Shadowing: start with period=3, change period to 9 mid-run → wrap still at 3; after clear and restart, wrap occurs at 9.
- period=0: oneshot=0 → tc every tick with timer_time=0; oneshot=1 → DONE after the first tick.
- Asynchronous reset asserted mid-count, between clock edges → all outputs are at reset values before the next edge; clear and start asserted together → IDLE, no count.
